// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: op and FSM encodings
// plus the request fault check used at acceptance.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // Misalignment for the access size, or a word index beyond the memory.
    function automatic logic lsu_fault(input lsu_op_e op, input logic [31:0] addr,
                                       input logic [31:0] mem_words);
        logic misaligned;
        misaligned = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            default:              misaligned = 1'b0;
        endcase
        return misaligned || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Big-endian byte/halfword extraction with sign/zero extension, and the
// read-modify-write merge used for sub-word stores.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/halfword (offset 0 is the most significant).
    always_comb begin
        byte_s = 8'h00;
        case (offset_i)
            2'd0:    byte_s = rword_i[31:24];
            2'd1:    byte_s = rword_i[23:16];
            2'd2:    byte_s = rword_i[15:8];
            2'd3:    byte_s = rword_i[7:0];
            default: byte_s = 8'h00;
        endcase
        half_s = offset_i[1] ? rword_i[15:0] : rword_i[31:16];
    end

    // Extend loads to 32 bits.
    always_comb begin
        load_data_o = 32'h0000_0000;
        case (lsu_op_e'(op_i))
            OP_LB:   load_data_o = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_data_o = {24'h00_0000, byte_s};
            OP_LH:   load_data_o = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_data_o = {16'h0000, half_s};
            OP_LW:   load_data_o = rword_i;
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane of the fetched word for SB/SH.
    always_comb begin
        store_word_o = rword_i;
        case (lsu_op_e'(op_i))
            OP_SB: begin
                case (offset_i)
                    2'd0:    store_word_o[31:24] = wdata_i[7:0];
                    2'd1:    store_word_o[23:16] = wdata_i[7:0];
                    2'd2:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd3:    store_word_o[7:0]   = wdata_i[7:0];
                    default: store_word_o = rword_i;
                endcase
            end
            OP_SH: begin
                if (offset_i[1]) begin
                    store_word_o[15:0] = wdata_i[15:0];
                end else begin
                    store_word_o[31:16] = wdata_i[15:0];
                end
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store unit between a MIPS pipeline and a word-addressed data memory;
// sub-word stores are done as read-modify-write.
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    lsu_state_e  state_q;
    lsu_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;
    logic [31:0] mem_address_q;
    logic [31:0] write_data_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    mips_lsu_align u_align (
        .op_i         (op_q),
        .offset_i     (addr_q[1:0]),
        .rword_i      (read_data),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_s),
        .store_word_o (store_word_s)
    );

    // Request FSM; every output is a register loaded on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LB;
            addr_q        <= 32'h0000_0000;
            wdata_q       <= 32'h0000_0000;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            resp_fault_q  <= 1'b0;
            mem_address_q <= 32'h0000_0000;
            write_data_q  <= 32'h0000_0000;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= lsu_op_e'(req_op);
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (lsu_fault(lsu_op_e'(req_op), req_addr, MEM_WORDS_W)) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else if (lsu_op_e'(req_op) == OP_SW) begin
                            state_q       <= ST_WR;
                            mem_address_q <= {2'b00, req_addr[31:2]};
                            write_data_q  <= req_wdata;
                            mem_write_q   <= 1'b1;
                        end else begin
                            state_q       <= ST_RD1;
                            mem_address_q <= {2'b00, req_addr[31:2]};
                            mem_read_q    <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD1: begin
                    state_q <= ST_RD2;
                end
                ST_RD2: begin
                    mem_read_q <= 1'b0;
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        state_q      <= ST_WR;
                        write_data_q <= store_word_s;
                        mem_write_q  <= 1'b1;
                    end else begin
                        state_q       <= ST_RESP;
                        mem_address_q <= 32'h0000_0000;
                        resp_valid_q  <= 1'b1;
                        resp_rdata_q  <= load_data_s;
                    end
                end
                ST_WR: begin
                    state_q       <= ST_RESP;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= 32'h0000_0000;
                    write_data_q  <= 32'h0000_0000;
                    resp_valid_q  <= 1'b1;
                    resp_rdata_q  <= 32'h0000_0000;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                    resp_fault_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    req_ready_q   <= 1'b1;
                    resp_valid_q  <= 1'b0;
                    resp_fault_q  <= 1'b0;
                    mem_read_q    <= 1'b0;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_fault    = resp_fault_q;
    assign mem_address   = mem_address_q;
    assign write_data    = write_data_q;
    assign sig_mem_read  = mem_read_q;
    assign sig_mem_write = mem_write_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a synchronous-read memory model.
module tb_mips_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    int          wr_cnt;
    int          rd_cnt;
    int          rv_cnt;
    int          overlap_cnt;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int err_cnt;
    int chk_cnt;

    mips_load_store_unit #(.MEM_WORDS(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_address   (mem_address),
        .write_data    (write_data),
        .sig_mem_read  (sig_mem_read),
        .sig_mem_write (sig_mem_write),
        .read_data     (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read, write on strobe, preload port for the bench.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (sig_mem_write) begin
            mem[mem_address[5:0]] <= write_data;
        end
        if (sig_mem_read) begin
            read_data <= mem[mem_address[5:0]];
        end
    end

    // Strobe and response activity counters.
    initial begin
        wr_cnt = 0; rd_cnt = 0; rv_cnt = 0; overlap_cnt = 0;
        last_wr_addr = 32'h0; last_wr_data = 32'h0;
    end
    always @(posedge clk) begin
        if (sig_mem_write) begin
            wr_cnt++;
            last_wr_addr = mem_address;
            last_wr_data = write_data;
        end
        if (sig_mem_read) rd_cnt++;
        if (sig_mem_read && sig_mem_write) overlap_cnt++;
        if (resp_valid) rv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request from IDLE; return latency (accept edge = 0) and response.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic f);
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        f  = resp_fault;
        @(posedge clk); #1;
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int exp_lat,
                           input logic [31:0] exp_rd, input logic exp_f);
        int          lat;
        logic [31:0] rd;
        logic        f;
        do_req(op, addr, wd, lat, rd, f);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_fault"}, {31'd0, f}, {31'd0, exp_f});
    endtask

    initial begin
        int wr0;
        int rd0;
        int rv0;
        int rdy_hi;
        int lat;
        err_cnt = 0; chk_cnt = 0;
        pl_en = 1'b0; pl_addr = 6'd0; pl_data = 32'h0;
        reset = 1'b1; req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset with req_valid high: must stay idle with cleared outputs.
        @(posedge clk); #1;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_fault", {31'd0, resp_fault}, 32'd0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_write_data", write_data, 32'h0);
        check_eq("rst_strobes", {30'd0, sig_mem_read, sig_mem_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);

        preload(6'd5, 32'h80F1_2233);
        preload(6'd8, 32'h1122_3344);
        preload(6'd63, 32'h0000_0000);

        // Loads with big-endian lane selection and extension.
        run_req("lb_15",  3'b000, 32'h15, 32'h0, 3, 32'hFFFF_FFF1, 1'b0);
        run_req("lbu_15", 3'b100, 32'h15, 32'h0, 3, 32'h0000_00F1, 1'b0);
        run_req("lb_14",  3'b000, 32'h14, 32'h0, 3, 32'hFFFF_FF80, 1'b0);
        run_req("lb_17",  3'b000, 32'h17, 32'h0, 3, 32'h0000_0033, 1'b0);
        run_req("lh_14",  3'b001, 32'h14, 32'h0, 3, 32'hFFFF_80F1, 1'b0);
        run_req("lhu_16", 3'b101, 32'h16, 32'h0, 3, 32'h0000_2233, 1'b0);

        // SH read-modify-write.
        wr0 = wr_cnt;
        run_req("sh_16", 3'b111, 32'h16, 32'h0000_ABCD, 4, 32'h0, 1'b0);
        check_eq("sh_16_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check_eq("sh_16_wr_addr", last_wr_addr, 32'd5);
        check_eq("sh_16_wr_data", last_wr_data, 32'h80F1_ABCD);
        run_req("lw_14_a", 3'b010, 32'h14, 32'h0, 3, 32'h80F1_ABCD, 1'b0);
        run_req("sb_14", 3'b110, 32'h14, 32'h0000_005A, 4, 32'h0, 1'b0);
        run_req("lw_14_b", 3'b010, 32'h14, 32'h0, 3, 32'h5AF1_ABCD, 1'b0);

        // Faults: no strobes, single-cycle latency.
        wr0 = wr_cnt; rd0 = rd_cnt;
        run_req("lw_102", 3'b010, 32'h102, 32'h0, 1, 32'h0, 1'b1);
        run_req("lw_100", 3'b010, 32'h100, 32'h0, 1, 32'h0, 1'b1);
        run_req("lh_15",  3'b001, 32'h15, 32'h0, 1, 32'h0, 1'b1);
        run_req("sh_17",  3'b111, 32'h17, 32'h1234, 1, 32'h0, 1'b1);
        run_req("sw_101", 3'b011, 32'h101, 32'h1234, 1, 32'h0, 1'b1);
        check_eq("fault_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);

        // SW to the last word, then read it back.
        wr0 = wr_cnt;
        run_req("sw_fc", 3'b011, 32'hFC, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        check_eq("sw_fc_wr_addr", last_wr_addr, 32'd63);
        check_eq("sw_fc_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        run_req("lw_fc", 3'b010, 32'hFC, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // SB abandoned by reset during RD2.
        wr0 = wr_cnt; rv0 = rv_cnt;
        req_op = 3'b110; req_addr = 32'h20; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_in_rd2", {31'd0, sig_mem_read}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort_strobes", {30'd0, sig_mem_read, sig_mem_write}, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        check_eq("abort_no_resp", 32'(rv_cnt - rv0), 32'd0);
        run_req("lw_20", 3'b010, 32'h20, 32'h0, 3, 32'h1122_3344, 1'b0);

        // Back-to-back with req_valid held high.
        req_op = 3'b010; req_addr = 32'h14; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 3'b100; req_addr = 32'h17;
        rdy_hi = 0; lat = 1;
        while (!resp_valid && lat < 12) begin
            if (req_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready) rdy_hi++;
        check_eq("b2b_busy_ready", 32'(rdy_hi), 32'd0);
        check_eq("b2b_lat1", 32'(lat), 32'd3);
        check_eq("b2b_rdata1", resp_rdata, 32'h5AF1_ABCD);
        @(posedge clk); #1;
        check_eq("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("b2b_accept2", {31'd0, req_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b2b_lat2", 32'(lat), 32'd3);
        check_eq("b2b_rdata2", resp_rdata, 32'h0000_00CD);
        @(posedge clk); #1;

        check_eq("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mips_load_store_unit.md
MIPS_LOAD_STORE_UNIT -- requirements
Module: mips_load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the downstream data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, meaning a pipeline memory request is present.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-006 SHALL have port req_op, input, 3, the operation code (encoding in REQ-028).
REQ-007 SHALL have port req_addr, input, 32, the byte address.
REQ-008 SHALL have port req_wdata, input, 32, the store data, right-justified for SB/SH.
REQ-009 SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, the extended load result, zero for stores and faults.
REQ-011 SHALL have port resp_fault, output, 1, meaning misaligned or out-of-range access.
REQ-012 SHALL have port mem_address, output, 32, the word index to data memory.
REQ-013 SHALL have port write_data, output, 32, the word to data memory.
REQ-014 SHALL have ports sig_mem_read and sig_mem_write, output, 1 each, the memory read and write strobes.
REQ-015 SHALL have port read_data, input, 32, the word returned by data memory.

Function
REQ-016 SHALL accept a request on the edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL register req_op, req_addr and req_wdata on acceptance; the registered copy SHALL be the only source used afterwards.
REQ-018 SHALL have FSM states IDLE, RD1, RD2, WR and RESP.
REQ-019 SHALL make these transitions:
- Loads: IDLE->RD1->RD2->RESP.
- SW: IDLE->WR->RESP.
- SB/SH: IDLE->RD1->RD2->WR->RESP.
- Faulting request: IDLE->RESP.
- RESP->IDLE always.
REQ-020 SHALL drive mem_address = byte address[31:2] zero-extended in RD1, RD2 and WR, and 0 otherwise.
REQ-021 SHALL assert sig_mem_read in RD1 and RD2 and capture read_data at the end of RD2.
REQ-022 SHALL assert sig_mem_write only in WR, and never together with sig_mem_read.
REQ-023 SHALL use big-endian byte numbering: byte offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = bits [31:16].
REQ-024 SHALL sign-extend loads for LB/LH and zero-extend them for LBU/LHU.
REQ-025 SHALL, for SB/SH, write the captured word with only the addressed byte or halfword replaced by req_wdata[7:0] or [15:0].
REQ-026 SHALL flag a fault on any of: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; word index >= MEM_WORDS. A faulting request SHALL issue no memory strobe and SHALL give resp_fault=1 and resp_rdata=0.
REQ-027 SHALL assert resp_valid only in RESP, holding resp_rdata and resp_fault valid in that cycle. Latency from the accept edge to resp_valid: loads 3 cycles, SW 2, SB/SH 4, fault 1.
REQ-028 SHALL decode req_op as: 000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH.

Reset
REQ-029 SHALL, while reset=1 at an edge, enter IDLE with req_ready=1 and all of the following 0: resp_valid, resp_rdata, resp_fault, mem_address, write_data, sig_mem_read, sig_mem_write.
REQ-030 SHALL abandon any in-flight operation on reset; an SB/SH reset before WR SHALL leave memory unmodified, and no resp_valid SHALL follow.
REQ-031 SHALL ignore req_valid in the reset cycle.

Structure
REQ-032 SHALL take the op encodings, FSM state encodings and the fault-check function from a shared package mips_lsu_pkg.
REQ-033 SHALL place extraction, extension and merge logic in one combinational sub-module mips_lsu_align, instantiated once.

Verification
REQ-034 SHALL cover: memory word 5 = 0x80F1_2233, LB at 0x15 -> resp_rdata 0xFFFF_FFF1 three cycles after accept; LBU at 0x15 -> 0x0000_00F1.
REQ-035 SHALL cover: word 5 = 0x80F1_2233, SH 0xABCD at 0x16 -> one WR cycle with write_data 0x80F1_ABCD and mem_address 5; resp_valid four cycles after accept with resp_fault=0.
REQ-036 SHALL cover: LW at 0x0000_0102 -> resp_fault=1 one cycle after accept, no strobes; LW at 0x100 with MEM_WORDS=64 -> resp_fault=1.
REQ-037 SHALL cover: SW 0xDEAD_BEEF at 0xFC -> write to word 63; then LW at 0xFC -> resp_rdata 0xDEAD_BEEF.
REQ-038 SHALL cover: SB 0x77 at 0x20 with reset asserted during RD2 -> no write strobe, word 8 unchanged, no resp_valid, req_ready=1 the cycle after reset.
REQ-039 SHALL cover: req_valid held high for back-to-back requests -> req_ready=0 from accept through RESP, next request accepted in the cycle after RESP.
